// File: rtl/alut_age_sweep12_if.sv
// alut_age_sweep12_if
//   Age port of the ALUT dual-port RAM. The sweeper is the master. It drives
//   the address, the write strobe and the write data. The RAM side is the
//   slave and returns read data one cycle after the address.
//   Signals:
//     mem_addr_age12       master->slave  8     age-port address
//     mem_write_age12      master->slave  1     1=write, 0=read
//     mem_write_data_age12 master->slave  DW12  write data
//     mem_read_data_age12  slave->master  DW12  read data (latency 1)
interface alut_age_sweep12_if #(
    parameter int DW12 = 83
);
    logic [7:0]      mem_addr_age12;
    logic            mem_write_age12;
    logic [DW12-1:0] mem_write_data_age12;
    logic [DW12-1:0] mem_read_data_age12;

    modport master (
        output mem_addr_age12,
        output mem_write_age12,
        output mem_write_data_age12,
        input  mem_read_data_age12
    );

    modport slave (
        input  mem_addr_age12,
        input  mem_write_age12,
        input  mem_write_data_age12,
        output mem_read_data_age12
    );
endinterface

// File: rtl/alut_age_sweep12.sv
// alut_age_sweep12
//   Ageing scheduler for the ALUT. A start pulse begins a sweep over every
//   address from 0 to DD12-1. For each address the sweeper reads the entry and
//   checks its timestamp against the current time. If the entry is stale, the
//   sweeper writes it back with the valid bit cleared. If the learn (add) port
//   touches the same address during that read-check-write window, the entry is
//   left alone.
//   Ports:
//     pclk12            in   clock, rising edge
//     n_p_reset12       in   synchronous active-low reset
//     sweep_start12     in   one-cycle sweep request (ignored while busy)
//     curr_time12       in   free-running time base
//     age_threshold12   in   max permitted age in time-base ticks
//     mem_addr_add12    in   add-port address (snooped)
//     mem_write_add12   in   add-port write strobe (snooped)
//     age_port          if   age-port RAM master (addr/write/wdata/rdata)
//     sweep_busy12      out  high from accepted start until done
//     sweep_done12      out  one-cycle pulse after the last address
//     aged_count12      out  entries invalidated in the last/current sweep
module alut_age_sweep12 #(
    parameter int DW12 = 83,
    parameter int DD12 = 256
) (
    input  logic                pclk12,
    input  logic                n_p_reset12,
    input  logic                sweep_start12,
    input  logic [31:0]         curr_time12,
    input  logic [31:0]         age_threshold12,
    input  logic [7:0]          mem_addr_add12,
    input  logic                mem_write_add12,
    alut_age_sweep12_if.master  age_port,
    output logic                sweep_busy12,
    output logic                sweep_done12,
    output logic [8:0]          aged_count12
);

    localparam int VALID_BIT = DW12 - 1;
    localparam int TS_MSB    = DW12 - 2;
    localparam int TS_LSB    = DW12 - 33;
    localparam logic [7:0] LAST_ADDR = 8'(DD12 - 1);
    localparam logic [8:0] COUNT_MAX = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WR,
        NXT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      ptr;
    logic [7:0]      ptr_next;
    logic            coll;
    logic            coll_next;
    logic [DW12-2:0] rd_q;
    logic [DW12-2:0] rd_q_next;
    logic [8:0]      count;
    logic [8:0]      count_next;
    logic            done_q;
    logic            done_next;
    logic            write_en;
    logic            add_hit;
    logic [31:0]     age;
    logic            stale;

    // The add port is writing the entry we are currently working on.
    assign add_hit = mem_write_add12 && (mem_addr_add12 == ptr);

    // The subtraction wraps modulo 2^32, so a time base that rolled over
    // still gives the correct age.
    assign age   = curr_time12 - age_port.mem_read_data_age12[TS_MSB:TS_LSB];
    assign stale = age_port.mem_read_data_age12[VALID_BIT] && (age > age_threshold12);

    always_ff @(posedge pclk12) begin
        if (!n_p_reset12) begin
            state  <= IDLE;
            ptr    <= 8'd0;
            coll   <= 1'b0;
            rd_q   <= '0;
            count  <= 9'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            coll   <= coll_next;
            rd_q   <= rd_q_next;
            count  <= count_next;
            done_q <= done_next;
        end
    end

    // Read data is valid in CHK, one cycle after RD drives the address.
    // A collision seen in RD or CHK blocks the write-back. A collision in
    // WR suppresses the strobe in the same cycle, so the add port always
    // wins. The strobe is also gated by reset, so nothing is written in a
    // reset cycle.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        coll_next  = coll;
        rd_q_next  = rd_q;
        count_next = count;
        done_next  = 1'b0;
        write_en   = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start12) begin
                    state_next = RD;
                    ptr_next   = 8'd0;
                    count_next = 9'd0;
                end
            end
            RD: begin
                coll_next  = add_hit;
                state_next = CHK;
            end
            CHK: begin
                rd_q_next = age_port.mem_read_data_age12[DW12-2:0];
                coll_next = coll | add_hit;
                if (stale && !coll && !add_hit) begin
                    state_next = WR;
                end else begin
                    state_next = NXT;
                end
            end
            WR: begin
                write_en = n_p_reset12 && !add_hit;
                if (write_en && (count != COUNT_MAX)) begin
                    count_next = count + 9'd1;
                end
                state_next = NXT;
            end
            NXT: begin
                if (ptr == LAST_ADDR) begin
                    state_next = IDLE;
                    ptr_next   = 8'd0;
                    done_next  = 1'b1;
                end else begin
                    state_next = RD;
                    ptr_next   = ptr + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign age_port.mem_addr_age12       = ptr;
    assign age_port.mem_write_age12      = write_en;
    assign age_port.mem_write_data_age12 = (state == WR) ? {1'b0, rd_q} : '0;
    assign sweep_busy12                  = (state != IDLE);
    assign sweep_done12                  = done_q;
    assign aged_count12                  = count;

endmodule
